// File: rtl/doodle_pkg.sv
// doodle_pkg: shared definitions for the doodle-jump game datapath.
//   - phase_e : vertical-controller phase encoding (IDLE/RISE/FALL/DEAD)
//   - ST_PLAY : top-level game-FSM code for the PLAY state
//   - SCREEN_H / Y_MAX : visible screen height and lowest valid feet row
//   - SCROLL_Y_DEF : default scroll line shared by the controller and shifter
package doodle_pkg;

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_RISE = 2'd1,
    PH_FALL = 2'd2,
    PH_DEAD = 2'd3
  } phase_e;

  localparam logic [1:0] ST_PLAY      = 2'd2;
  localparam int         SCREEN_H     = 480;
  localparam int         Y_MAX        = SCREEN_H - 1;
  localparam int         SCROLL_Y_DEF = 200;

endpackage

// File: rtl/frame_tick_gen.sv
// frame_tick_gen: per-frame strobe divider.
//   clk  in  system clock
//   rst  in  synchronous reset, active-high
//   en   in  count enable; low clears the divider
//   tick out high for the one cycle in which the divider wraps
// The counter runs 0..TICK_DIV-1 while en is high, so the first tick comes
// on the TICK_DIV-th enabled clock edge after en rises.
module frame_tick_gen #(
  parameter int TICK_DIV = 416667
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int              CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]   LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrap;

  // Wrap detection and next count; tick is combinational so the consumer
  // can register it alongside its own frame-cycle updates.
  always_comb begin
    wrap  = en && (cnt_q == LAST);
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
  end

  // Divider register; held at zero whenever counting is disabled.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = wrap;

endmodule

// File: rtl/doodle_vert_ctrl.sv
// doodle_vert_ctrl: vertical player physics and scroll controller.
// Once per frame it integrates jump/gravity, clamps the player at the scroll
// line (turning any rise above it into a one-cycle adv pulse for the platform
// shifter) and detects falls past the bottom edge.
//   clk          in   system clock
//   rst          in   synchronous reset, active-high
//   state_i      in   top-level game state (ST_PLAY = 2)
//   land_hit_i   in   feet-on-platform flag, sampled on frame cycles
//   spring_hit_i in   feet-on-spring flag (only with DOODLE_SPRING_EN)
//   frame_o      out  one-cycle frame strobe
//   adv_o        out  scroll advance in px, non-zero only with frame_o
//   player_y_o   out  player feet y, 0..479
//   phase_o      out  0 IDLE, 1 RISE, 2 FALL, 3 DEAD
//   game_over_o  out  high while phase is DEAD
// Build option: define DOODLE_SPRING_EN to make spring_hit_i active.
import doodle_pkg::*;

module doodle_vert_ctrl #(
  parameter int TICK_DIV = 416667,
  parameter int JUMP_V   = 12,
  parameter int GRAVITY  = 1,
  parameter int VMAX     = 8,
  parameter int SCROLL_Y = SCROLL_Y_DEF,
  parameter int START_Y  = 400,
  parameter int SPRING_V = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] state_i,
  input  logic       land_hit_i,
  input  logic       spring_hit_i,
  output logic       frame_o,
  output logic [3:0] adv_o,
  output logic [8:0] player_y_o,
  output logic [1:0] phase_o,
  output logic       game_over_o
);

  // All physics math is 10 bits wide so y +/- speed never wraps 9-bit y.
  localparam logic [9:0] SCROLL10 = 10'(SCROLL_Y);
  localparam logic [9:0] GRAV10   = 10'(GRAVITY);
  localparam logic [9:0] VMAX10   = 10'(VMAX);
  localparam logic [9:0] YMAX10   = 10'(Y_MAX);
  localparam logic [8:0] START9   = 9'(START_Y);
  localparam logic [3:0] JUMP4    = 4'(JUMP_V);
`ifdef DOODLE_SPRING_EN
  localparam logic [3:0] SPRING4  = 4'(SPRING_V);
`else
  logic unused_spring;
  assign unused_spring = spring_hit_i;
`endif

  logic       in_play;
  logic       tick;

  phase_e     phase_q, phase_d;
  logic [3:0] vel_q, vel_d;
  logic [8:0] y_q, y_d;
  logic [3:0] adv_q, adv_d;
  logic       frame_q;

  logic [9:0] y10, d10, vsub10, vfall10;

  assign in_play = (state_i == ST_PLAY);

  frame_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .en  (in_play),
    .tick(tick)
  );

  // Next-state physics. Nothing moves outside a frame cycle, and adv defaults
  // to zero because the shifter accumulates it on every clock.
  always_comb begin
    phase_d = phase_q;
    vel_d   = vel_q;
    y_d     = y_q;
    adv_d   = '0;

    y10     = {1'b0, y_q};
    d10     = {6'b0, vel_q};
    vsub10  = (d10 > GRAV10) ? (d10 - GRAV10) : '0;
    vfall10 = ((d10 + GRAV10) > VMAX10) ? VMAX10 : (d10 + GRAV10);

    if (tick) begin
      case (phase_q)
        PH_IDLE: begin
          phase_d = PH_RISE;
          vel_d   = JUMP4;
        end
        PH_RISE: begin
          // Any part of the step that would cross the scroll line becomes
          // scroll advance instead of player movement.
          if (y10 >= (SCROLL10 + d10)) begin
            y_d = 9'(y10 - d10);
          end else begin
            adv_d = 4'(d10 - (y10 - SCROLL10));
            y_d   = 9'(SCROLL10);
          end
          vel_d = 4'(vsub10);
          if (vsub10 == '0) begin
            phase_d = PH_FALL;
          end
        end
        PH_FALL: begin
`ifdef DOODLE_SPRING_EN
          if (spring_hit_i) begin
            phase_d = PH_RISE;
            vel_d   = SPRING4;
          end else
`endif
          if (land_hit_i) begin
            phase_d = PH_RISE;
            vel_d   = JUMP4;
          end else if ((y10 + vfall10) > YMAX10) begin
            phase_d = PH_DEAD;
            y_d     = 9'(YMAX10);
            vel_d   = '0;
          end else begin
            y_d   = 9'(y10 + vfall10);
            vel_d = 4'(vfall10);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Leaving PLAY (or reset) returns everything to the start-of-play state,
  // even in the middle of a frame.
  always_ff @(posedge clk) begin
    if (rst || !in_play) begin
      phase_q <= PH_IDLE;
      vel_q   <= '0;
      y_q     <= START9;
      adv_q   <= '0;
      frame_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      vel_q   <= vel_d;
      y_q     <= y_d;
      adv_q   <= adv_d;
      frame_q <= tick;
    end
  end

  assign frame_o     = frame_q;
  assign adv_o       = adv_q;
  assign player_y_o  = y_q;
  assign phase_o     = phase_q;
  assign game_over_o = (phase_q == PH_DEAD);

endmodule
